// File: rtl/vga_timing_pkg.sv
// Purpose : shared constants and helpers for the VGA timing generator.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Holds the 640x480@60 default mode, the line/frame total derivation and
// the minimum counter width needed to hold the default totals.
package vga_timing_pkg;

  // 640x480@60 (25.175 MHz nominal pixel clock) default mode.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 4;

  // Period of a line or frame: active + front porch + sync + back porch.
  function automatic int seg_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = seg_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = seg_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Smallest counter width that holds both default maxima (800-1, 525-1).
  localparam int DEF_CW = $clog2((DEF_H_TOTAL > DEF_V_TOTAL) ? DEF_H_TOTAL : DEF_V_TOTAL);

  // True when a cw-bit counter can reach h_total-1 and v_total-1.
  function automatic bit cw_fits(input int cw, input int h_total, input int v_total);
    return ((h_total - 1) < (1 << cw)) && ((v_total - 1) < (1 << cw));
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Purpose : divides the system clock into a one-cycle pixel enable.
// Latency : first pix_en in cycle CLK_DIV after reset release, then every CLK_DIV cycles.
// Backpr. : none; free-running.
// Ports   : clk, rst_n (async active-low) in; pix_en out (high when div_cnt==CLK_DIV-1).
module pix_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  // CLK_DIV==1 still needs a 1-bit counter; it just never leaves 0.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + DW'(1);
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign pix_en = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : parametrised VGA timing generator (sync, blanking, coordinates, strobes).
// Latency : sync/video_on/xpos/ypos registered from next-state counters, so zero skew to h/v counts.
// Backpr. : none; free-running from reset.
// Ports   : clk, rst_n in; pix_en, hsync, vsync, video_on, xpos, ypos, line_start,
//           frame_start out; frame_count out only when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW       = DEF_CW,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] xpos,
  output logic [CW-1:0] ypos,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam bit CW_FITS = cw_fits(CW, H_TOTAL, V_TOTAL);

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic [CW-1:0] xpos_q, xpos_d;
  logic [CW-1:0] ypos_q, ypos_d;

  pix_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_clk_en (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en)
  );

  // An undersized CW would alias the totals and never wrap correctly.
  always_ff @(posedge clk) begin
    assert (CW_FITS);
  end

  // Outputs are decoded from the next-state counts so that, once registered,
  // they line up exactly with h_cnt_q/v_cnt_q without a pipeline offset.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end
    hsync_d    = ((h_cnt_d >= HS_BEG) && (h_cnt_d < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d    = ((v_cnt_d >= VS_BEG) && (v_cnt_d < VS_END)) ? VS_POL : ~VS_POL;
    video_on_d = (h_cnt_d < H_ACT_C) && (v_cnt_d < V_ACT_C);
    xpos_d     = video_on_d ? h_cnt_d : '0;
    ypos_d     = video_on_d ? v_cnt_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      hsync_q    <= ~HS_POL;
      vsync_q    <= ~VS_POL;
      video_on_q <= 1'b1;
      xpos_q     <= '0;
      ypos_q     <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign line_start  = pix_en && (h_cnt_q == '0);
  assign frame_start = line_start && (v_cnt_q == '0);

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Counts on the edge that ends the frame_start cycle; wraps naturally.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  // No frame counter in this build.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct {
    int cyc;
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
    bit ls;
    bit fs;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pe_cnt = 0;

  // Default-mode DUT (640x480, CLK_DIV=4, negative syncs).
  logic       pix_en_a, hsync_a, vsync_a, video_on_a, ls_a, fs_a;
  logic [9:0] xpos_a, ypos_a;
  // Small DUT: H=8/1/2/1, V=4/1/1/1, CLK_DIV=1, positive syncs.
  logic       pix_en_s, hsync_s, vsync_s, video_on_s, ls_s, fs_s;
  logic [9:0] xpos_s, ypos_s;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_a, frame_count_s;
`endif

  vga_timing_gen dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .video_on    (video_on_a),
    .xpos        (xpos_a),
    .ypos        (ypos_a),
    .line_start  (ls_a),
    .frame_start (fs_a)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (frame_count_a)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b1), .CLK_DIV (1)
  ) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .video_on    (video_on_s),
    .xpos        (xpos_s),
    .ypos        (ypos_s),
    .line_start  (ls_s),
    .frame_start (fs_s)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (frame_count_s)
`endif
  );

  // Scoreboard queues.
  pix_t q_a[$];
  pix_t q_s[$];
  int   q_hsw_a[$];  // hsync asserted width, default DUT
  int   q_hsw_s[$];
  int   q_vsw_s[$];
  int   q_lsp_a[$];  // line_start period
  int   q_lsp_s[$];
  int   q_fsp_s[$];  // frame_start period

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic pix_t mk(input int cyc, input int x, input int y, input bit hs,
                              input bit vs, input bit von, input bit ls, input bit fs);
    pix_t e;
    e.cyc = cyc; e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.von = von; e.ls = ls; e.fs = fs;
    return e;
  endfunction

  task automatic cmp_pix(input string tag, input pix_t e, input int x, input int y,
                         input bit hs, input bit vs, input bit von, input bit ls, input bit fs);
    chk($sformatf("%s_xpos@%0d", tag, e.cyc), x, e.x);
    chk($sformatf("%s_ypos@%0d", tag, e.cyc), y, e.y);
    chk($sformatf("%s_hsync@%0d", tag, e.cyc), hs, e.hs);
    chk($sformatf("%s_vsync@%0d", tag, e.cyc), vs, e.vs);
    chk($sformatf("%s_video_on@%0d", tag, e.cyc), von, e.von);
    chk($sformatf("%s_line_start@%0d", tag, e.cyc), ls, e.ls);
    chk($sformatf("%s_frame_start@%0d", tag, e.cyc), fs, e.fs);
  endtask

  // Cycle 1 is the cycle in which reset is released (released just after a posedge).
  always @(posedge clk) begin
    if (!rst_n) pe_cnt = 0;
    else        pe_cnt++;
  end

  // Monitors: pop expectations whenever the DUT presents pix_en.
  always @(negedge clk) begin
    int cur;
    pix_t e;
    if (rst_n && pix_en_a) begin
      cur = pe_cnt + 1;
      while (q_a.size() > 0 && q_a[0].cyc < cur) begin
        chk("a_pix_missed_cyc", cur, q_a[0].cyc);
        void'(q_a.pop_front());
      end
      if (q_a.size() > 0 && q_a[0].cyc == cur) begin
        e = q_a.pop_front();
        cmp_pix("a", e, int'(xpos_a), int'(ypos_a), hsync_a, vsync_a, video_on_a, ls_a, fs_a);
      end
    end
  end

  always @(negedge clk) begin
    int cur;
    pix_t e;
    if (rst_n && pix_en_s) begin
      cur = pe_cnt + 1;
      while (q_s.size() > 0 && q_s[0].cyc < cur) begin
        chk("s_pix_missed_cyc", cur, q_s[0].cyc);
        void'(q_s.pop_front());
      end
      if (q_s.size() > 0 && q_s[0].cyc == cur) begin
        e = q_s.pop_front();
        cmp_pix("s", e, int'(xpos_s), int'(ypos_s), hsync_s, vsync_s, video_on_s, ls_s, fs_s);
      end
    end
  end

  // Asserted-width monitors: a run is reported when the sync deasserts.
  int run_hs_a = 0, run_hs_s = 0, run_vs_s = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run_hs_a = 0; run_hs_s = 0; run_vs_s = 0;
    end else begin
      if (hsync_a == 1'b0) run_hs_a++;
      else if (run_hs_a != 0) begin
        if (q_hsw_a.size() > 0) chk("a_hsync_width", run_hs_a, q_hsw_a.pop_front());
        run_hs_a = 0;
      end
      if (hsync_s == 1'b1) run_hs_s++;
      else if (run_hs_s != 0) begin
        if (q_hsw_s.size() > 0) chk("s_hsync_width", run_hs_s, q_hsw_s.pop_front());
        run_hs_s = 0;
      end
      if (vsync_s == 1'b1) run_vs_s++;
      else if (run_vs_s != 0) begin
        if (q_vsw_s.size() > 0) chk("s_vsync_width", run_vs_s, q_vsw_s.pop_front());
        run_vs_s = 0;
      end
    end
  end

  // Strobe period monitors.
  int last_ls_a = -1, last_ls_s = -1, last_fs_s = -1;
  always @(negedge clk) begin
    int cur;
    if (!rst_n) begin
      last_ls_a = -1; last_ls_s = -1; last_fs_s = -1;
    end else begin
      cur = pe_cnt + 1;
      if (ls_a) begin
        if (last_ls_a >= 0 && q_lsp_a.size() > 0)
          chk("a_line_start_period", cur - last_ls_a, q_lsp_a.pop_front());
        last_ls_a = cur;
      end
      if (ls_s) begin
        if (last_ls_s >= 0 && q_lsp_s.size() > 0)
          chk("s_line_start_period", cur - last_ls_s, q_lsp_s.pop_front());
        last_ls_s = cur;
      end
      if (fs_s) begin
        if (last_fs_s >= 0 && q_fsp_s.size() > 0)
          chk("s_frame_start_period", cur - last_fs_s, q_fsp_s.pop_front());
        last_fs_s = cur;
      end
    end
  end

  task automatic push_first_pixels_a();
    // Pixel k (k=0..2) is presented at cycle 4*(k+1).
    q_a.push_back(mk(4,  0, 0, 1, 1, 1, 1, 1));
    q_a.push_back(mk(8,  1, 0, 1, 1, 1, 0, 0));
    q_a.push_back(mk(12, 2, 0, 1, 1, 1, 0, 0));
  endtask

  task automatic check_queues_empty(input string tag);
    chk({tag, "_q_a_left"}, q_a.size(), 0);
    chk({tag, "_q_s_left"}, q_s.size(), 0);
    chk({tag, "_q_width_left"}, q_hsw_a.size() + q_hsw_s.size() + q_vsw_s.size(), 0);
    chk({tag, "_q_period_left"}, q_lsp_a.size() + q_lsp_s.size() + q_fsp_s.size(), 0);
  endtask

`ifdef VGA_FRAME_COUNT_EN
  initial begin
    @(posedge rst_n);
    @(negedge clk);                       // cycle 1: first frame_start on small DUT
    chk("fc_before_first_frame", frame_count_s, 16'h0000);
    @(negedge clk);                       // cycle 2
    chk("fc_after_first_frame", frame_count_s, 16'h0001);
    repeat (48) @(negedge clk);           // cycle 50, mid-frame
    force dut_s.frame_count_q = 16'hFFFF;
    #1;
    release dut_s.frame_count_q;
    repeat (35) @(negedge clk);           // cycle 85: second frame_start
    chk("fc_preloaded", frame_count_s, 16'hFFFF);
    @(negedge clk);                       // cycle 86
    chk("fc_wrap", frame_count_s, 16'h0000);
  end
`endif

  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    chk("rst_a_pix_en", pix_en_a, 0);
    chk("rst_a_hsync", hsync_a, 1);
    chk("rst_a_vsync", vsync_a, 1);
    chk("rst_a_video_on", video_on_a, 1);
    chk("rst_a_xpos", xpos_a, 0);
    chk("rst_a_ypos", ypos_a, 0);
    chk("rst_s_pix_en", pix_en_s, 1);
    chk("rst_s_hsync", hsync_s, 0);
    chk("rst_s_vsync", vsync_s, 0);

    // Default DUT: first line and start of second.
    push_first_pixels_a();
    q_a.push_back(mk(2560, 639, 0, 1, 1, 1, 0, 0));
    q_a.push_back(mk(2564, 0,   0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(2624, 0,   0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(2628, 0,   0, 0, 1, 0, 0, 0));
    q_a.push_back(mk(3008, 0,   0, 0, 1, 0, 0, 0));
    q_a.push_back(mk(3012, 0,   0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(3200, 0,   0, 1, 1, 0, 0, 0));
    q_a.push_back(mk(3204, 0,   1, 1, 1, 1, 1, 0));
    q_a.push_back(mk(3216, 3,   1, 1, 1, 1, 0, 0));
    q_hsw_a.push_back(384);
    q_lsp_a.push_back(3200);

    // Small DUT: H_TOTAL=12, V_TOTAL=7, one pixel per cycle.
    q_s.push_back(mk(1,  0, 0, 0, 0, 1, 1, 1));
    q_s.push_back(mk(9,  0, 0, 0, 0, 0, 0, 0));
    q_s.push_back(mk(10, 0, 0, 1, 0, 0, 0, 0));
    q_s.push_back(mk(11, 0, 0, 1, 0, 0, 0, 0));
    q_s.push_back(mk(12, 0, 0, 0, 0, 0, 0, 0));
    q_s.push_back(mk(20, 7, 1, 0, 0, 1, 0, 0));
    q_s.push_back(mk(49, 0, 0, 0, 0, 0, 1, 0));
    q_s.push_back(mk(61, 0, 0, 0, 1, 0, 1, 0));
    q_s.push_back(mk(72, 0, 0, 0, 1, 0, 0, 0));
    q_s.push_back(mk(73, 0, 0, 0, 0, 0, 1, 0));
    q_s.push_back(mk(85, 0, 0, 0, 0, 1, 1, 1));
    q_hsw_s.push_back(2); q_hsw_s.push_back(2); q_hsw_s.push_back(2);
    q_vsw_s.push_back(12);
    q_lsp_s.push_back(12); q_lsp_s.push_back(12);
    q_fsp_s.push_back(84); q_fsp_s.push_back(84);

    rst_n = 1'b1;
    repeat (3300) @(posedge clk);
    check_queues_empty("phase1");

    // Find the default DUT's hsync asserted, then reset mid-pulse.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (hsync_a == 1'b0) found = 1'b1;
    end
    chk("hsync_seen_before_reset", found, 1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_a_hsync", hsync_a, 1);
    chk("midrst_a_xpos", xpos_a, 0);
    chk("midrst_a_ypos", ypos_a, 0);
    chk("midrst_a_video_on", video_on_a, 1);
    chk("midrst_a_pix_en", pix_en_a, 0);

    repeat (3) @(posedge clk);
    push_first_pixels_a();
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_queues_empty("phase2");
    chk("phase2_a_xpos_at_cyc21", xpos_a, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
